// File: rtl/bus_scheduler.sv
// Frame scheduler sharing one bus between an SPI bridge and a 6502-style CPU.
// Each frame has two halves: half A belongs to SPI, half B to the CPU unless stopped.
module bus_scheduler #(
  parameter int HALF_CYCLES = 8
) (
  input  logic clk16_i,
  input  logic rst_ni,
  input  logic spi_valid_i,
  input  logic cpu_stop_i,
  output logic spi_ready_o,
  output logic spi_en_o,
  output logic cpu_en_o,
  output logic cpu_clk_o,
  output logic cpu_be_o,
  output logic setup_clk_o,
  output logic strobe_clk_o,
  output logic stopped_o
);

  // state   | meaning
  // RUN     | half A is an SPI slot, half B is a CPU slot
  // STOPPED | CPU frozen with PHI2 low, both halves are SPI slots

  localparam int FRAME = 2 * HALF_CYCLES;
  localparam int PW    = $clog2(FRAME);
  localparam int SW    = PW - 1;

  typedef enum logic {
    RUN     = 1'b0,
    STOPPED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic            started_q;
  logic            armed_q, armed_d;
  logic            gnt_q, gnt_d;

  logic [SW-1:0]   s_d;
  logic            half_b_d;
  logic            frame_end;
  logic            slot_start;
  logic            spi_slot;
  logic            grant;

  logic spi_ready_d, spi_en_d, cpu_en_d, cpu_clk_d, cpu_be_d, setup_clk_d, strobe_clk_d;
  logic spi_ready_q, spi_en_q, cpu_en_q, cpu_clk_q, cpu_be_q, setup_clk_q, strobe_clk_q;

  // Outputs are registered from the phase being entered, so p_d drives all decode.
  // The first edge after reset release lands on p = 0 rather than advancing past it.
  always_comb begin
    p_d        = started_q ? p_q + PW'(1) : '0;
    s_d        = p_d[SW-1:0];
    half_b_d   = p_d[PW-1];
    frame_end  = started_q && (p_q == PW'(FRAME - 1));
    slot_start = (s_d == '0);
  end

  always_ff @(posedge clk16_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      p_q       <= '0;
      started_q <= 1'b0;
      armed_q   <= 1'b1;
      gnt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      started_q <= 1'b1;
      armed_q   <= armed_d;
      gnt_q     <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = cpu_stop_i ? STOPPED : RUN;
    end
  end

  // A grant is only decided at slot start and then held for the whole half.
  always_comb begin
    spi_slot = (state_d == STOPPED) || !half_b_d;
    grant    = slot_start && spi_slot && spi_valid_i && armed_q;
    gnt_d    = slot_start ? grant : gnt_q;
    if (!spi_valid_i) begin
      armed_d = 1'b1;
    end else if (grant) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  always_comb begin
    cpu_clk_d    = (state_d == RUN) && half_b_d;
    cpu_en_d     = cpu_clk_d && !slot_start;
    spi_en_d     = gnt_d && !slot_start;
    spi_ready_d  = !spi_en_d;
    cpu_be_d     = !((state_d == STOPPED) || gnt_d);
    setup_clk_d  = (s_d >= SW'(1)) && (s_d <= SW'(3));
    strobe_clk_d = (s_d >= SW'(4)) && (s_d <= SW'(HALF_CYCLES - 2));
  end

  always_ff @(posedge clk16_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spi_ready_q  <= 1'b1;
      spi_en_q     <= 1'b0;
      cpu_en_q     <= 1'b0;
      cpu_clk_q    <= 1'b0;
      cpu_be_q     <= 1'b1;
      setup_clk_q  <= 1'b0;
      strobe_clk_q <= 1'b0;
    end else begin
      spi_ready_q  <= spi_ready_d;
      spi_en_q     <= spi_en_d;
      cpu_en_q     <= cpu_en_d;
      cpu_clk_q    <= cpu_clk_d;
      cpu_be_q     <= cpu_be_d;
      setup_clk_q  <= setup_clk_d;
      strobe_clk_q <= strobe_clk_d;
    end
  end

  assign spi_ready_o  = spi_ready_q;
  assign spi_en_o     = spi_en_q;
  assign cpu_en_o     = cpu_en_q;
  assign cpu_clk_o    = cpu_clk_q;
  assign cpu_be_o     = cpu_be_q;
  assign setup_clk_o  = setup_clk_q;
  assign strobe_clk_o = strobe_clk_q;
  assign stopped_o    = (state_q == STOPPED);

endmodule

// File: tb/tb_bus_scheduler.sv
// Scoreboard bench for bus_scheduler: a frame-level model queues the expected
// output vector each cycle and a negedge monitor compares against the DUT.
module tb_bus_scheduler;

  localparam int H = 8;
  localparam int F = 2 * H;
  localparam logic [7:0] RST_VEC = 8'b1000_1000;

  logic clk16_i = 1'b0;
  logic rst_ni  = 1'b0;
  logic spi_valid_i = 1'b0;
  logic cpu_stop_i  = 1'b0;
  logic spi_ready_o, spi_en_o, cpu_en_o, cpu_clk_o, cpu_be_o;
  logic setup_clk_o, strobe_clk_o, stopped_o;

  bus_scheduler #(.HALF_CYCLES(H)) dut (
    .clk16_i     (clk16_i),
    .rst_ni      (rst_ni),
    .spi_valid_i (spi_valid_i),
    .cpu_stop_i  (cpu_stop_i),
    .spi_ready_o (spi_ready_o),
    .spi_en_o    (spi_en_o),
    .cpu_en_o    (cpu_en_o),
    .cpu_clk_o   (cpu_clk_o),
    .cpu_be_o    (cpu_be_o),
    .setup_clk_o (setup_clk_o),
    .strobe_clk_o(strobe_clk_o),
    .stopped_o   (stopped_o)
  );

  always #5 clk16_i = ~clk16_i;

  typedef struct {
    logic [7:0] vec;
    int         p;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Frame-level reference: which half we are in, who owns it, and whether
  // the current SPI slot was handed out.
  int m_p;
  bit m_started, m_stopped, m_armed, m_granted;

  function automatic void m_reset();
    m_p = 0; m_started = 0; m_stopped = 0; m_armed = 1; m_granted = 0;
  endfunction

  function automatic void m_step(bit v, bit stp);
    int np;
    bit spi_owned;
    bit g;
    np = m_started ? (m_p + 1) % F : 0;
    if (m_started && m_p == F - 1) m_stopped = stp;
    m_started = 1;
    m_p = np;
    spi_owned = m_stopped || (np < H);
    g = 0;
    if (np % H == 0) begin
      g = spi_owned && v && m_armed;
      m_granted = g;
    end
    if (!v) m_armed = 1;
    else if (g) m_armed = 0;
  endfunction

  function automatic logic [7:0] m_out();
    int s;
    bit cpu_half, in_access, bus_spi;
    s = m_p % H;
    cpu_half  = !m_stopped && (m_p >= H);
    in_access = (s != 0);
    bus_spi   = m_granted && in_access;
    return {!bus_spi, bus_spi, cpu_half && in_access, cpu_half,
            !(m_stopped || m_granted), (s >= 1 && s <= 3),
            (s >= 4 && s <= H - 2), m_stopped};
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk16_i);
    if (!rst_ni) begin
      m_reset();
      e.vec = RST_VEC;
    end else begin
      m_step(spi_valid_i, cpu_stop_i);
      e.vec = m_out();
    end
    e.p = m_p;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_vec(string name, logic [7:0] exp_vec, logic [7:0] mask);
    logic [7:0] got;
    got = {spi_ready_o, spi_en_o, cpu_en_o, cpu_clk_o, cpu_be_o,
           setup_clk_o, strobe_clk_o, stopped_o};
    tests++;
    if ((got & mask) !== (exp_vec & mask)) begin
      failed++;
      $display("FAIL %s t=%0t got=%b exp=%b mask=%b", name, $time, got, exp_vec, mask);
    end
  endtask

  // Called just after a posedge: the expectation already queued for this
  // cycle is replaced because the asynchronous reset overrides it.
  task automatic async_reset();
    exp_t e;
    rst_ni = 1'b0;
    void'(exp_q.pop_back());
    m_reset();
    e.vec = RST_VEC;
    e.p   = 0;
    exp_q.push_back(e);
  endtask

  task automatic run_to_phase(int ph);
    for (int i = 0; i < 2 * F && m_p != ph; i++) tick();
  endtask

  always @(negedge clk16_i) begin
    exp_t e;
    logic [7:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {spi_ready_o, spi_en_o, cpu_en_o, cpu_clk_o, cpu_be_o,
             setup_clk_o, strobe_clk_o, stopped_o};
      tests++;
      if (got !== e.vec) begin
        failed++;
        $display("FAIL scoreboard t=%0t p=%0d {rdy,spi_en,cpu_en,phi2,be,setup,strobe,stopped} got=%b exp=%b",
                 $time, e.p, got, e.vec);
      end
    end
  end

  initial begin
    m_reset();
    repeat (3) tick();
    check_vec("reset_state", RST_VEC, 8'hFF);
    rst_ni = 1'b1;

    // idle RUN frames
    repeat (3 * F) tick();

    // request raised at p=14 and held: one grant only
    run_to_phase(14);
    spi_valid_i = 1'b1;
    repeat (3 * F) tick();
    spi_valid_i = 1'b0;
    repeat (4) tick();

    // request raised mid-slot at p=3 waits for next frame
    run_to_phase(3);
    spi_valid_i = 1'b1;
    run_to_phase(1);
    check_vec("expired_wait_grant", 8'b0100_0000, 8'b1100_1000);
    repeat (F) tick();
    spi_valid_i = 1'b0;
    repeat (F) tick();

    // stop the CPU, toggle the request every half, then release
    run_to_phase(10);
    cpu_stop_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_to_phase((i % 2 == 0) ? 14 : 6);
      spi_valid_i = ~spi_valid_i;
    end
    run_to_phase(12);
    cpu_stop_i  = 1'b0;
    spi_valid_i = 1'b0;
    repeat (2 * F) tick();

    // reset during a granted slot with the request still high
    run_to_phase(12);
    spi_valid_i = 1'b1;
    run_to_phase(5);
    async_reset();
    #1;
    check_vec("async_reset", RST_VEC, 8'hFF);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (2 * F) tick();
    spi_valid_i = 1'b0;
    repeat (4) tick();

    // randomized traffic with occasional stop requests and resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!rst_ni) begin
        if ($urandom_range(0, 2) == 0) rst_ni = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end
      if ($urandom_range(0, 5) == 0) spi_valid_i = ~spi_valid_i;
      if ($urandom_range(0, 39) == 0) cpu_stop_i = ~cpu_stop_i;
    end
    rst_ni = 1'b1;
    repeat (F) tick();

    @(negedge clk16_i);
    @(negedge clk16_i);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 SHALL take parameter HALF_CYCLES, default 8, meaning clk16_i cycles per bus half-frame (power of two, >= 8); one frame is 2*HALF_CYCLES cycles, 1 MHz CPU at default.
REQ-002 SHALL have port clk16_i  input  1  the 16 MHz system clock; it is the only clock.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port spi_valid_i  input  1  level: an MCU bus transaction is pending (addr, data and rw_n stable).
REQ-005 SHALL have port cpu_stop_i  input  1  level: request to freeze the CPU and give both halves to SPI.
REQ-006 SHALL have port spi_ready_o  output  1  high = no transaction in progress, next command accepted.
REQ-007 SHALL have port spi_en_o  output  1  SPI owns the bus (addr/rw/data drive window).
REQ-008 SHALL have port cpu_en_o  output  1  CPU access window; also the 1-per-frame video clock enable.
REQ-009 SHALL have port cpu_clk_o  output  1  6502 PHI2.
REQ-010 SHALL have port cpu_be_o  output  1  CPU bus enable; 0 tri-states the CPU address/rw.
REQ-011 SHALL have port setup_clk_o  output  1  address-setup phase marker.
REQ-012 SHALL have port strobe_clk_o  output  1  write strobe; its falling edge is the read-capture edge.
REQ-013 SHALL have port stopped_o  output  1  CPU frozen (state STOPPED).

Function
REQ-014 SHALL keep a phase counter p, 0..2*HALF_CYCLES-1, incrementing every cycle, wrapping to 0; s = p mod HALF_CYCLES; half A = lower half, half B = upper half.
REQ-015 SHALL register every output (no combinational path from any input to any output).
REQ-016 SHALL drive setup_clk_o high for s = 1..3 and strobe_clk_o high for s = 4..HALF_CYCLES-2 in every half, regardless of owner.
REQ-017 SHALL implement states RUN and STOPPED; in RUN, half A is an SPI slot and half B a CPU slot; in STOPPED, both halves are SPI slots.
REQ-018 SHALL sample cpu_stop_i only at p = 2*HALF_CYCLES-1; RUN->STOPPED if 1, STOPPED->RUN if 0, state takes effect at p = 0; no other transitions.
REQ-019 SHALL, in RUN, drive cpu_clk_o high exactly for half B and cpu_en_o high for s = 1..HALF_CYCLES-1 of half B; in STOPPED, both SHALL be held 0 (PHI2 stopped low, no runt pulses).
REQ-020 SHALL hold an armed flag; armed is set whenever spi_valid_i is sampled 0 and cleared on grant.
REQ-021 SHALL grant an SPI slot at s = 0 of that slot iff spi_valid_i = 1 and armed = 1; a pending request arriving after s = 0 waits for the next SPI slot.
REQ-022 SHALL, for a granted slot, drive spi_en_o high for s = 1..HALF_CYCLES-1 and cpu_be_o low for s = 0..HALF_CYCLES-1.
REQ-023 SHALL drop spi_ready_o on the cycle after the grant and raise it at s = 0 of the following half; exactly one bus access per spi_valid_i assertion.
REQ-024 SHALL keep cpu_be_o low throughout STOPPED, and high in every ungranted slot in RUN.
REQ-025 SHALL never assert spi_en_o and cpu_en_o in the same cycle.
REQ-026 SHALL not change state or abort a granted slot if cpu_stop_i or spi_valid_i changes mid-slot; spi_valid_i falling mid-slot only sets armed.

Reset
REQ-027 SHALL, while rst_ni = 0, force p = 0, state RUN, armed = 1, spi_ready_o = 1, cpu_be_o = 1, stopped_o = 0, and all other outputs 0.
REQ-028 SHALL abort any in-progress slot on reset (spi_en_o drops asynchronously) and resume at p = 0 with half A, s = 0 on the first clk16_i edge after release.

Verification
REQ-029 Idle RUN, spi_valid_i = 0 -> cpu_clk_o period 16 cycles, high p = 8..15; cpu_en_o high p = 9..15; spi_en_o never 1; spi_ready_o constant 1.
REQ-030 spi_valid_i raised at p = 14, held -> grant at p = 0, spi_en_o p = 1..7, cpu_be_o low p = 0..7, spi_ready_o low p = 1..7, high at p = 8; no second grant until spi_valid_i falls and rises.
REQ-031 spi_valid_i raised at p = 3 -> no grant this frame; grant at next p = 0.
REQ-032 cpu_stop_i = 1 sampled at p = 15 with spi_valid_i toggled each slot -> stopped_o = 1 from p = 0, cpu_clk_o held 0, SPI grants at p = 0 and p = 8; release at p = 15 -> PHI2 resumes at p = 8.
REQ-033 rst_ni pulsed low at p = 5 of a granted slot -> spi_en_o 0 immediately, spi_ready_o 1; after release p counts from 0 and a still-high spi_valid_i is granted at p = 0.
